dmem_arbiter: RTL and testbench

Shares the single-port `data_mem` between up to N requesters: core load/store port (port 0), program loader and debug/DMA ports. Round-robin arbitration with a per-port req/gnt/rvalid handshake and a fixed two-cycle read pipeline. Bounds-checks addresses. Sits between the requesters and `data_mem` in the `cpu` top; `data_mem` pins connect directly to the `o_mem_*`/`i_mem_rdata` ports.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: pipeline stage records
// and the address range/alignment check.
package dmem_arb_pkg;

    // Stage records carry addresses at this fixed width; the arbiter's AW must not exceed it.
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PORT_W = 2;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              err;
    } cmd_t;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
        logic [31:0]       rdata;
        logic              err;
    } resp_t;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < ADDR_W'(words));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins, and
// next_ptr names the port after the winner (ptr is returned unchanged when idle).
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] next_ptr
);

    localparam int unsigned PW = $clog2(N_REQ);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = PW'((32'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                next_ptr = PW'((32'(idx) + 1) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the single-port data_mem among N_REQ requesters,
// with a two-stage CMD/RESP pipeline and address bounds checking.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned AW         = 32,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ-1:0]    i_we,
    input  logic [N_REQ*AW-1:0] i_addr,
    input  logic [N_REQ*32-1:0] i_wdata,
    output logic [N_REQ-1:0]    o_gnt,
    output logic [N_REQ-1:0]    o_rvalid,
    output logic [31:0]         o_rdata,
    output logic                o_err,
    output logic                o_mem_we,
    output logic [AW-1:0]       o_mem_addr,
    output logic [31:0]         o_mem_wdata,
    input  logic [31:0]         i_mem_rdata
);

    localparam int unsigned PW = $clog2(N_REQ);

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     next_ptr;
    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  gnt;
    logic [PORT_W-1:0] sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    cmd_t              cmd;
    resp_t             resp;

    assign arb_req = i_reset ? '0 : i_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req      (arb_req),
        .ptr      (rr_ptr),
        .gnt      (gnt),
        .next_ptr (next_ptr)
    );

    assign o_gnt = gnt;

    always_comb begin
        sel_port  = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt[k]) begin
                sel_port  = PORT_W'(k);
                sel_we    = i_we[k];
                sel_addr  = ADDR_W'(i_addr[k*AW +: AW]);
                sel_wdata = i_wdata[k*32 +: 32];
            end
        end
    end

    // CMD address/data only load on a grant so the memory pins hold while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rr_ptr <= '0;
            cmd    <= '0;
            resp   <= '0;
        end else begin
            rr_ptr    <= next_ptr;
            cmd.valid <= |gnt;
            if (|gnt) begin
                cmd.port  <= sel_port;
                cmd.we    <= sel_we;
                cmd.addr  <= sel_addr;
                cmd.wdata <= sel_wdata;
                cmd.err   <= !addr_ok(sel_addr, DMEM_WORDS);
            end
            resp.valid <= cmd.valid;
            resp.port  <= cmd.port;
            resp.rdata <= (cmd.valid && !cmd.we && !cmd.err) ? i_mem_rdata : '0;
            resp.err   <= cmd.valid && cmd.err;
        end
    end

    assign o_mem_we    = cmd.valid && cmd.we && !cmd.err && !i_reset;
    assign o_mem_addr  = AW'(cmd.addr);
    assign o_mem_wdata = cmd.wdata;

    always_comb begin
        o_rvalid = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            o_rvalid[k] = resp.valid && !i_reset && (resp.port == PORT_W'(k));
        end
    end

    assign o_rdata = resp.rdata;
    assign o_err   = resp.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, checked
// against a transaction-level model of arbitration order and memory contents.
module tb_dmem_arbiter;

    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int WORDS = 1024;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [N-1:0]    i_req = '0;
    logic [N-1:0]    i_we = '0;
    logic [N*AW-1:0] i_addr = '0;
    logic [N*32-1:0] i_wdata = '0;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_rvalid;
    logic [31:0]     o_rdata;
    logic            o_err;
    logic            o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [31:0]     o_mem_wdata;
    logic [31:0]     i_mem_rdata;

    always #5 i_clk = ~i_clk;

    dmem_arbiter #(.N_REQ(N), .AW(AW), .DMEM_WORDS(WORDS)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_gnt       (o_gnt),
        .o_rvalid    (o_rvalid),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    // data_mem stand-in: combinational read, write on rising edge
    logic [31:0] mem [0:WORDS-1];
    assign i_mem_rdata = mem[o_mem_addr[11:2]];
    always @(posedge i_clk) if (o_mem_we) mem[o_mem_addr[11:2]] <= o_mem_wdata;

    // reference model: transactions in grant order against an ideal memory
    typedef struct {
        int        port;
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        bit        err;
        int        due;
    } txn_t;

    txn_t        pend[$];
    bit   [31:0] ref_mem [0:WORDS-1];
    int          ptr = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit   [1:0]  req_v = '0;
    bit   [1:0]  we_v = '0;
    bit   [31:0] addr_v [2];
    bit   [31:0] wd_v [2];
    bit   [1:0]  last_gnt;
    bit   [31:0] saved;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit bad_addr(input bit [31:0] a);
        return (a % 4 != 0) || (a / 4 >= WORDS);
    endfunction

    task automatic step(input bit rst);
        bit   [1:0]  eg;
        int          win;
        bit   [1:0]  erv;
        bit   [31:0] erd;
        bit          ee;
        bit          busy;
        i_reset = rst;
        i_req   = req_v;
        i_we    = we_v;
        i_addr  = {addr_v[1], addr_v[0]};
        i_wdata = {wd_v[1], wd_v[0]};
        #1;
        eg  = '0;
        win = -1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                int p;
                p = (ptr + i) % N;
                if (win < 0 && req_v[p]) win = p;
            end
        end
        if (win >= 0) eg[win] = 1'b1;
        chk("gnt", 32'(o_gnt), 32'(eg));

        erv = '0; erd = '0; ee = 1'b0;
        foreach (pend[j]) if (pend[j].due == cyc) begin
            erv[pend[j].port] = 1'b1;
            erd = pend[j].rdata;
            ee  = pend[j].err;
        end
        if (rst) begin
            chk("rvalid_in_reset", 32'(o_rvalid), 32'd0);
            chk("mem_we_in_reset", 32'(o_mem_we), 32'd0);
        end else begin
            chk("rvalid", 32'(o_rvalid), 32'(erv));
            chk("rdata", o_rdata, erd);
            chk("err", 32'(o_err), 32'(ee));
            chk("rr_ptr", 32'(dut.rr_ptr), 32'(ptr));
            busy = 1'b0;
            foreach (pend[j]) if (pend[j].due == cyc + 1) begin
                busy = 1'b1;
                chk("mem_addr", o_mem_addr, pend[j].addr);
                chk("mem_we", 32'(o_mem_we), 32'(pend[j].we && !pend[j].err));
                if (pend[j].we && !pend[j].err) chk("mem_wdata", o_mem_wdata, pend[j].wdata);
            end
            if (!busy) chk("mem_we_idle", 32'(o_mem_we), 32'd0);
        end

        // effect of the coming clock edge
        if (rst) begin
            pend.delete();
            ptr = 0;
        end else begin
            for (int j = pend.size() - 1; j >= 0; j--) if (pend[j].due == cyc) pend.delete(j);
            foreach (pend[j]) if (pend[j].due == cyc + 1) begin
                if (pend[j].we) begin
                    if (!pend[j].err) ref_mem[pend[j].addr / 4] = pend[j].wdata;
                end else begin
                    pend[j].rdata = pend[j].err ? 32'd0 : ref_mem[pend[j].addr / 4];
                end
            end
            if (win >= 0) begin
                txn_t t;
                t.port  = win;
                t.we    = we_v[win];
                t.addr  = addr_v[win];
                t.wdata = wd_v[win];
                t.rdata = '0;
                t.err   = bad_addr(addr_v[win]);
                t.due   = cyc + 2;
                pend.push_back(t);
                ptr = (win + 1) % N;
            end
        end
        last_gnt = eg;
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        req_v = '0;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic put(input int p, input bit we, input bit [31:0] a, input bit [31:0] d);
        req_v[p]  = 1'b1;
        we_v[p]   = we;
        addr_v[p] = a;
        wd_v[p]   = d;
    endtask

    function automatic bit [31:0] rand_addr();
        int r;
        r = int'($urandom_range(15, 0));
        if (r < 12) return 32'($urandom_range(31, 0)) * 4;
        if (r < 14) return 32'($urandom_range(31, 0)) * 4 + 32'($urandom_range(3, 1));
        return 32'h1000 + 32'($urandom_range(63, 0)) * 4;
    endfunction

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        addr_v[0] = '0; addr_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;
        @(negedge i_clk);

        // reset with requests pending: no grant while reset is high
        req_v = 2'b11;
        step(1'b1);
        step(1'b1);
        req_v = '0;
        step(1'b0);
        chk("mem_addr_after_reset", o_mem_addr, 32'd0);
        chk("mem_wdata_after_reset", o_mem_wdata, 32'd0);
        chk("rdata_after_reset", o_rdata, 32'd0);

        // single read of mem[4]
        put(0, 1'b0, 32'h10, 32'd0);
        step(1'b0);
        idle(3);

        // contention from reset: alternating grants and responses
        step(1'b1);
        put(0, 1'b0, 32'h10, 32'd0);
        put(1, 1'b0, 32'h14, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0);
        idle(3);

        // write then read of the same word in consecutive cycles
        put(1, 1'b1, 32'h20, 32'h12345678);
        step(1'b0);
        req_v = '0;
        put(0, 1'b0, 32'h20, 32'd0);
        step(1'b0);
        idle(3);
        chk("raw_mem", mem[8], 32'h12345678);

        // misaligned read, out-of-range write
        saved = ref_mem[0];
        put(0, 1'b0, 32'h1002, 32'd0);
        step(1'b0);
        req_v = '0;
        put(1, 1'b1, 32'h1000, 32'hCAFEF00D);
        step(1'b0);
        idle(3);
        chk("oob_write_mem0", mem[0], saved);

        // reset while a write is in the command stage
        saved = ref_mem[12];
        put(0, 1'b1, 32'h30, 32'hA5A5A5A5);
        step(1'b0);
        req_v = '0;
        step(1'b1);
        idle(3);
        chk("reset_write_mem", mem[12], saved);

        // port 1 withdraws while port 0 is granted
        step(1'b1);
        put(0, 1'b0, 32'h40, 32'd0);
        put(1, 1'b0, 32'h44, 32'd0);
        step(1'b0);
        req_v = '0;
        step(1'b0);
        idle(3);

        // randomized traffic with held requests, withdrawals and occasional resets
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_v[p]) begin
                    if ($urandom_range(1, 0) == 1) put(p, 1'($urandom_range(1, 0)), rand_addr(), $urandom);
                end else if ($urandom_range(15, 0) == 0) begin
                    req_v[p] = 1'b0;
                end
            end
            step($urandom_range(63, 0) == 0);
            for (int p = 0; p < N; p++) if (last_gnt[p]) req_v[p] = 1'b0;
        end
        idle(3);
        for (int i = 0; i < 32; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
